// File: rtl/debug_uart_dumper_pkg.sv
// Shared constants, FSM state encoding and the nibble-to-ASCII helper for the debug dumper.
package debug_uart_dumper_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // pc, inst, then x0..x31
    localparam int unsigned NUM_WORDS = 34;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_DIGIT  = 3'd3;
    localparam state_t ST_SEP    = 3'd4;
    localparam state_t ST_FINISH = 3'd5;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/debug_uart_dumper_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface; accepts a byte only when idle.
module debug_uart_dumper_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic               active;
    logic [9:0]         frame;
    logic [3:0]         bit_cnt;
    logic [TIMER_W-1:0] timer;

    // Load a {stop, data, start} frame on handshake, then shift it out one bit per bit period
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            active  <= 1'b0;
            frame   <= '1;
            bit_cnt <= 4'd0;
            timer   <= '0;
        end else if (!active) begin
            if (valid) begin
                active  <= 1'b1;
                frame   <= {1'b1, data, 1'b0};
                bit_cnt <= 4'd0;
                timer   <= '0;
            end
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
            frame <= {1'b1, frame[9:1]};
            if (bit_cnt == 4'd9) begin
                active <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Line idles high whenever no frame is in flight, including during reset
    always_comb begin
        ready = !active;
        tx    = active ? frame[0] : 1'b1;
    end

endmodule

// File: rtl/debug_uart_dumper.sv
// Snapshots pc/inst, walks x0..x31 through the debug read port and streams all 34 words as
// space-separated uppercase hex terminated by CR LF over a UART.
module debug_uart_dumper import debug_uart_dumper_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] reg_data_in,
    output logic [4:0]  reg_addr_out,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    state_t              state;
    logic [5:0]          idx;
    logic [2:0]          nib;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [31:0]         word;
    logic [31:0]         pc_snap;
    logic [31:0]         inst_snap;
    logic                lf_pending;

    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       xfer;

    // Byte offered to the UART; derived only from state that changes on transfer, so it is stable
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = ASCII_SPACE;
        case (state)
            ST_DIGIT: begin
                byte_valid = 1'b1;
                byte_data  = nibble_to_ascii(word[31:28]);
            end
            ST_SEP: begin
                byte_valid = 1'b1;
                if (idx == LAST_IDX) begin
                    byte_data = lf_pending ? ASCII_LF : ASCII_CR;
                end
            end
            default: ;
        endcase
    end

    // FINISH drains the last frame; done fires once the UART is idle again
    always_comb begin
        xfer = byte_valid && byte_ready;
        done = (state == ST_FINISH) && byte_ready;
        busy = (state != ST_IDLE) && !done;
    end

    // Dump sequencer: word select, register settle wait, digit issue and separators
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            idx          <= 6'd0;
            nib          <= 3'd0;
            settle_cnt   <= '0;
            word         <= 32'd0;
            pc_snap      <= 32'd0;
            inst_snap    <= 32'd0;
            lf_pending   <= 1'b0;
            reg_addr_out <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc_snap   <= pc_in;
                        inst_snap <= inst_in;
                        idx       <= 6'd0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    nib        <= 3'd0;
                    lf_pending <= 1'b0;
                    if (idx == 6'd0) begin
                        word  <= pc_snap;
                        state <= ST_DIGIT;
                    end else if (idx == 6'd1) begin
                        word  <= inst_snap;
                        state <= ST_DIGIT;
                    end else begin
                        // idx 2..33 -> x0..x31; modulo-32 subtract handles 32 and 33
                        reg_addr_out <= idx[4:0] - 5'd2;
                        settle_cnt   <= '0;
                        state        <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        word  <= reg_data_in;
                        state <= ST_DIGIT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_DIGIT: begin
                    if (xfer) begin
                        word <= {word[27:0], 4'h0};
                        nib  <= nib + 3'd1;
                        if (nib == 3'd7) begin
                            state <= ST_SEP;
                        end
                    end
                end
                ST_SEP: begin
                    if (xfer) begin
                        if (idx != LAST_IDX) begin
                            idx   <= idx + 6'd1;
                            state <= ST_LOAD;
                        end else if (!lf_pending) begin
                            lf_pending <= 1'b1;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    if (byte_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    debug_uart_dumper_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk    (clk),
        .aresetn(aresetn),
        .data   (byte_data),
        .valid  (byte_valid),
        .ready  (byte_ready),
        .tx     (tx)
    );

endmodule

// File: tb/tb_debug_uart_dumper.sv
// Bench for debug_uart_dumper: UART decoder, delayed register-file model, table of expected words.
module tb_debug_uart_dumper;

    localparam int CPB    = 4;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] inst_in = 32'd0;
    logic [31:0] reg_data_in;
    logic [4:0]  reg_addr_out;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debug_uart_dumper #(
        .CLKS_PER_BIT (CPB),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .start       (start),
        .pc_in       (pc_in),
        .inst_in     (inst_in),
        .reg_data_in (reg_data_in),
        .reg_addr_out(reg_addr_out),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    // Register file whose read data lags the address by SETTLE-1 cycles
    logic [4:0] addr_d;
    logic       dead_mode = 1'b0;
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) addr_d <= 5'd0;
        else          addr_d <= reg_addr_out;
    end
    assign reg_data_in = (dead_mode && addr_d == 5'd5) ? 32'hDEADBEEF
                                                       : 32'h11111111 * {27'd0, addr_d};

    // UART receiver sampling mid-bit on the falling clock edge
    logic [7:0] rx_q[$];
    int         rx_frame_err = 0;
    logic       rx_active;
    int         rx_pos;
    logic [7:0] rx_shift;
    always @(negedge clk) begin
        if (!aresetn) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active <= 1'b1;
                rx_pos    <= 1;
            end
        end else begin
            rx_pos <= rx_pos + 1;
            if (rx_pos % CPB == CPB / 2) begin
                if (rx_pos / CPB == 0) begin
                    if (tx !== 1'b0) rx_frame_err <= rx_frame_err + 1;
                end else if (rx_pos / CPB <= 8) begin
                    rx_shift[rx_pos / CPB - 1] <= tx;
                end else begin
                    if (tx !== 1'b1) rx_frame_err <= rx_frame_err + 1;
                    rx_q.push_back(rx_shift);
                    rx_active <= 1'b0;
                end
            end
        end
    end

    typedef struct {
        int          run;
        int          word;
        logic [31:0] value;
    } vec_t;

    vec_t  vecs[14];
    string hexchars = "0123456789ABCDEF";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input int w, input logic [31:0] exp);
        string act_s;
        string exp_s;
        bit    ok;
        logic [7:0] b;
        logic [7:0] e;
        act_s = "";
        exp_s = "";
        ok = 1'b1;
        checks++;
        for (int i = 0; i < 8; i++) begin
            e = hexchars[int'(exp[31-4*i -: 4])];
            b = (rx_q.size() > 9 * w + i) ? rx_q[9 * w + i] : 8'h3F;
            act_s = $sformatf("%s%c", act_s, b);
            exp_s = $sformatf("%s%c", exp_s, e);
            if (b !== e) ok = 1'b0;
        end
        if (!ok) begin
            failures++;
            $display("FAIL %s word%0d: got \"%s\" expected \"%s\"", name, w, act_s, exp_s);
        end
    endtask

    task automatic run_table(input int run);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].run == run) check_word($sformatf("run%0d", run), vecs[i].word, vecs[i].value);
        end
    endtask

    task automatic check_stream(input string name);
        bit seps_ok;
        check({name, "_bytes"}, rx_q.size(), 307);
        seps_ok = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (rx_q.size() <= 9 * i + 8 || rx_q[9 * i + 8] !== 8'h20) seps_ok = 1'b0;
        end
        check({name, "_spaces"}, 32'(seps_ok), 1);
        check({name, "_cr"}, (rx_q.size() > 305) ? rx_q[305] : 8'hFF, 8'h0D);
        check({name, "_lf"}, (rx_q.size() > 306) ? rx_q[306] : 8'hFF, 8'h0A);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Wait for done; optionally fire ignored starts at bytes 10, 200 and in the done cycle
    task automatic wait_done(input int bound, input bit inject, output bit got,
                             output logic busy_at, output logic busy_prev);
        logic prev;
        bit   p10;
        bit   p200;
        prev = busy;
        p10 = 1'b0;
        p200 = 1'b0;
        got = 1'b0;
        busy_at = 1'bx;
        busy_prev = 1'bx;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (inject) begin
                start = 1'b0;
                if (rx_q.size() == 10 && !p10) begin
                    start = 1'b1;
                    p10 = 1'b1;
                end
                if (rx_q.size() == 200 && !p200) begin
                    start = 1'b1;
                    p200 = 1'b1;
                end
            end
            if (done === 1'b1) begin
                got = 1'b1;
                busy_at = busy;
                busy_prev = prev;
                if (inject) start = 1'b1;
            end
            prev = busy;
        end
    endtask

    initial begin
        bit         got;
        bit         bad;
        logic       busy_at;
        logic       busy_prev;
        int         k;
        logic [9:0] fr;

        vecs[0]  = '{0, 0, 32'h00000004};
        vecs[1]  = '{0, 1, 32'h00500093};
        vecs[2]  = '{0, 2, 32'h00000000};
        vecs[3]  = '{0, 3, 32'h11111111};
        vecs[4]  = '{0, 17, 32'hFFFFFFFF};
        vecs[5]  = '{0, 18, 32'h11111110};
        vecs[6]  = '{0, 33, 32'h1111110F};
        vecs[7]  = '{0, 7, 32'h55555555};
        vecs[8]  = '{1, 0, 32'h0BADF00D};
        vecs[9]  = '{1, 6, 32'h44444444};
        vecs[10] = '{1, 7, 32'hDEADBEEF};
        vecs[11] = '{1, 8, 32'h66666666};
        vecs[12] = '{2, 0, 32'hCAFE0001};
        vecs[13] = '{2, 33, 32'h1111110F};

        // Reset state
        pc_in = 32'h00000004;
        inst_in = 32'h00500093;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_addr", 32'(reg_addr_out), 0);
        @(negedge clk) aresetn = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("idle_after_reset", 32'(bad), 0);

        // Run 0: full dump with frame timing on the first three bytes
        rx_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1;
        while (tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("first_start_edge", 32'(tx), 0);
        check("start_latency_ok", 32'((k - 1) <= SETTLE + 4), 1);
        for (int byt = 0; byt < 3; byt++) begin
            if (byt > 0) begin
                k = 0;
                while (tx !== 1'b0 && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                check($sformatf("next_start_b%0d", byt), 32'(tx), 0);
            end
            fr = {1'b1, 8'h30, 1'b0};
            for (int b = 0; b < 10; b++) begin
                bad = 1'b0;
                for (int c = 0; c < CPB; c++) begin
                    if (!(b == 0 && c == 0)) @(negedge clk);
                    if (tx !== fr[b]) bad = 1'b1;
                end
                check($sformatf("frame_b%0d_bit%0d", byt, b), 32'(bad), 0);
            end
        end
        pc_in = 32'hFFFFFFFF;
        inst_in = 32'hAAAAAAAA;
        wait_done(20000, 1'b0, got, busy_at, busy_prev);
        check("run0_done_seen", 32'(got), 1);
        check("run0_busy_at_done", 32'(busy_at), 0);
        check("run0_busy_before_done", 32'(busy_prev), 1);
        check("run0_addr_holds", 32'(reg_addr_out), 31);
        @(negedge clk);
        check("run0_done_one_cycle", 32'(done), 0);
        check_stream("run0");
        run_table(0);

        // Run 1: letters, settle timing and ignored starts
        dead_mode = 1'b1;
        pc_in = 32'h0BADF00D;
        rx_q.delete();
        pulse_start();
        wait_done(20000, 1'b1, got, busy_at, busy_prev);
        @(negedge clk) start = 1'b0;
        check("run1_done_seen", 32'(got), 1);
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        check("run1_no_second_dump", 32'(bad), 0);
        check_stream("run1");
        run_table(1);
        dead_mode = 1'b0;

        // Run 2: reset during a low data bit of byte 50, then a fresh dump
        pc_in = 32'hCAFE0001;
        rx_q.delete();
        pulse_start();
        k = 0;
        while (rx_q.size() < 50 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("run2_reached_byte50", rx_q.size(), 50);
        k = 0;
        while (tx !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3 * CPB + 1) @(negedge clk);
        check("run2_bit2_low", 32'(tx), 0);
        #1 aresetn = 1'b0;
        #1;
        check("midreset_tx", 32'(tx), 1);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_addr", 32'(reg_addr_out), 0);
        repeat (3) @(negedge clk);
        check("midreset_tx_held", 32'(tx), 1);
        aresetn = 1'b1;
        rx_q.delete();
        repeat (5) @(negedge clk);
        check("postreset_idle", 32'(busy), 0);
        pulse_start();
        wait_done(20000, 1'b0, got, busy_at, busy_prev);
        check("run2_done_seen", 32'(got), 1);
        check_stream("run2");
        run_table(2);
        check("frame_errors", 32'(rx_frame_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
